// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and constants for the memory-stage SRAM controller.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int CNT_W = $clog2(16);
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter with a zero flag for half-word transfer timing.
module sram_wait_counter
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec) count <= count - 1'b1;
  end
  assign zero = (count == '0);
endmodule

// File: rtl/sram_stall_ctrl.sv
// sram_stall_ctrl: splits 32-bit loads/stores into two 16-bit SRAM transfers, freezing the pipeline meanwhile.
// Define SRAM_STALL_STATS_EN to add rd_count/wr_count/stall_count statistics outputs.
module sram_stall_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
`ifdef SRAM_STALL_STATS_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [31:0]       stall_count,
`endif
  output logic              sram_we_n
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);
  state_t state, state_n;
  logic op_wr, req, in_phase, start, cnt_zero;
  logic [ADDR_W-2:0] word_q, word_n;
  logic [31:0] wdata_q;
  assign req      = rd_en | wr_en;
  assign in_phase = (state == LO) | (state == HI);
  assign start    = (state == IDLE) & req;
  assign word_n   = (ADDR_W-1)'((address - BASE_ADDR) >> 2);
  sram_wait_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start | (in_phase & cnt_zero)),
    .dec      (in_phase & ~cnt_zero),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = req ? LO : IDLE;
      LO:   state_n = cnt_zero ? HI : LO;
      HI:   state_n = cnt_zero ? DONE : HI;
      DONE: state_n = IDLE;
    endcase
    ready       = (state == DONE) | ((state == IDLE) & ~req);
    sram_addr   = in_phase ? {word_q, (state == HI) ? HALF_HI : HALF_LO} : '0;
    sram_dq_oe  = in_phase & op_wr;
    sram_dq_out = sram_dq_oe ? ((state == HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0;
    // last cycle of each write phase releases the strobe so data/address hold past it
    sram_we_n   = ~(sram_dq_oe & (~cnt_zero | (WAIT_CYCLES == 1)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op_wr   <= wr_en;
        word_q  <= word_n;
        wdata_q <= write_data;
      end
      if (in_phase && cnt_zero && !op_wr) begin
        if (state == HI) read_data[31:16] <= sram_dq_in;
        else read_data[15:0] <= sram_dq_in;
      end
    end
  end
`ifdef SRAM_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == DONE && !op_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
      if (state == DONE && op_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
      if (!ready) stall_count <= stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_stall_ctrl.sv
// tb_sram_stall_ctrl: scoreboard bench with a behavioural 16-bit SRAM model.
module tb_sram_stall_ctrl;
  localparam int ADDR_W = 18;
  localparam int WAIT = 2;
  typedef struct {logic [ADDR_W-1:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic [31:0] rd; int stall;} done_t;
  logic clk = 0, rst = 1, rd_en = 0, wr_en = 0;
  logic [31:0] address = 0, write_data = 0, read_data;
  logic ready, sram_dq_oe, sram_we_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
`ifdef SRAM_STALL_STATS_EN
  logic [15:0] rd_count, wr_count;
  logic [31:0] stall_count;
`endif
  logic [15:0] mem [256];
  logic [15:0] shadow [256];
  wr_t wr_q [$];
  done_t done_q [$];
  wr_t wexp;
  done_t dexp;
  logic [31:0] last_rd = 0;
  int checks = 0, errors = 0;
  int exp_rd = 0, exp_wr = 0, exp_stall = 0;
  int stall = 0, low_len = 0;
  logic prev_we = 1;

  sram_stall_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
`ifdef SRAM_STALL_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count), .stall_count(stall_count),
`endif
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
      low_len = 0;
      prev_we = 1;
    end else begin
      if (!sram_we_n) begin
        if (prev_we) begin
          if (wr_q.size() == 0) chk("unexpected_write", wr_q.size(), 1);
          else begin
            wexp = wr_q.pop_front();
            chk("wr_addr", sram_addr, wexp.a);
            chk("wr_data", sram_dq_out, wexp.d);
            chk("wr_oe", sram_dq_oe, 1);
          end
        end
        low_len++;
      end else if (!prev_we) begin
        chk("we_low_len", low_len, WAIT - 1);
        low_len = 0;
      end
      prev_we = sram_we_n;
      if (!ready) stall++;
      else if (stall > 0) begin
        if (done_q.size() == 0) chk("unexpected_done", done_q.size(), 1);
        else begin
          dexp = done_q.pop_front();
          chk("read_data", read_data, dexp.rd);
          chk("stall_len", stall, dexp.stall);
          chk("done_we_n", sram_we_n, 1);
        end
        stall = 0;
      end
    end
  end

  task automatic push_half(input logic [31:0] a, input logic hi, input logic [15:0] d);
    wr_t x;
    x.a = {(ADDR_W-1)'((a - 32'd1024) >> 2), hi};
    x.d = d;
    wr_q.push_back(x);
    shadow[x.a[7:0]] = d;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    done_t e;
    logic [7:0] i;
    bit ok = 0;
    i = 8'({(ADDR_W-1)'((a - 32'd1024) >> 2), 1'b0});
    if (wr) begin
      push_half(a, 1'b0, d[15:0]);
      push_half(a, 1'b1, d[31:16]);
      exp_wr++;
    end else begin
      last_rd = {shadow[i + 8'd1], shadow[i]};
      exp_rd++;
    end
    e.rd = last_rd;
    e.stall = 1 + 2 * WAIT;
    done_q.push_back(e);
    exp_stall += 1 + 2 * WAIT;
    @(posedge clk);
    #1 rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1;
        break;
      end
    end
    chk("done_reached", ok, 1);
    #1 rd_en = 0; wr_en = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_we_n"}, sram_we_n, 1);
    chk({tag, "_oe"}, sram_dq_oe, 0);
    chk({tag, "_rdata"}, read_data, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_dq_out"}, sram_dq_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 7 + 3);
      shadow[i] = 16'(i * 7 + 3);
    end
    repeat (2) @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 0;
    do_op(0, 1, 32'd1028, 32'hDEADBEEF);
    do_op(1, 0, 32'd1028, 32'h0);
    repeat (3) @(negedge clk);
    chk("rd_hold", read_data, 32'hDEADBEEF);
    do_op(1, 1, 32'd1032, 32'h12345678);
    @(negedge clk);
    chk("conflict_rd_kept", read_data, 32'hDEADBEEF);
    do_op(1, 0, 32'd1032, 32'h0);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic w;
      a = 32'd1024 + 32'(4 * $urandom_range(0, 40));
      w = 1'($urandom_range(0, 1));
      do_op(!w, w, a, $urandom);
    end
    // start a write and reset it in the first cycle of its high phase
    push_half(32'd1040, 1'b0, 16'h5A5A);
    @(posedge clk);
    #1 wr_en = 1; address = 32'd1040; write_data = 32'hA5A55A5A;
    repeat (3) @(posedge clk);
    #1 rst = 1; wr_en = 0;
    wr_q.delete();
    done_q.delete();
    last_rd = 0;
    exp_rd = 0; exp_wr = 0; exp_stall = 0;
    #1 check_idle("midreset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    do_op(1, 0, 32'd1024, 32'h0);
    do_op(0, 1, 32'd1028, 32'hCAFEF00D);
    do_op(0, 1, 32'd1036, 32'h0BADC0DE);
    do_op(1, 0, 32'd1036, 32'h0);
`ifdef SRAM_STALL_STATS_EN
    @(negedge clk);
    chk("rd_count", rd_count, 16'(exp_rd));
    chk("wr_count", wr_count, 16'(exp_wr));
    chk("stall_count", stall_count, 32'(exp_stall));
`endif
    repeat (2) @(negedge clk);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
